// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared opcodes, FSM encoding and immediate decoders for the fetch PC sequencer.
package fetch_pc_ctrl_pkg;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        FPC_BOOT  = 2'd0,
        FPC_RUN   = 2'd1,
        FPC_FLUSH = 2'd2
    } fpc_state_e;

    function automatic logic [31:0] imm_b(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] ins);
        return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction
endpackage

// File: rtl/Predicter.sv
// Static predictor: JAL and backward conditional branches taken, everything else pc+4.
module Predicter
    import fetch_pc_ctrl_pkg::*;
(
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic [31:0] o_pred_pc
);
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_j;

    assign w_imm_b = imm_b(i_instr);
    assign w_imm_j = imm_j(i_instr);

    always_comb begin
        o_pred_pc = i_pc + 32'd4;
        if (i_instr[6:0] == OPCODE_JAL)
            o_pred_pc = i_pc + w_imm_j;
        else if (i_instr[6:0] == OPCODE_BRANCH && w_imm_b[31])
            o_pred_pc = i_pc + w_imm_b;
    end
endmodule

// File: rtl/pred_queue.sv
// In-order FIFO of predicted next-PCs; clear wins over push and pop.
module pred_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic        i_clear,
    input  logic [31:0] i_data,
    output logic [31:0] o_head,
    output logic        o_full,
    output logic        o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear)
            r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end
endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer: static prediction, in-order resolve queue, flush/redirect on mispredict.
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_valid,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [31:0]      if_instr,
    output logic [31:0]      if_pc,
    output logic [31:0]      if_pred_pc,
    input  logic             resolve_valid,
    input  logic [31:0]      resolve_next_pc,
    output logic             flush,
    output logic             q_full,
    output logic [CNT_W-1:0] mispredict_cnt,
    output logic [CNT_W-1:0] resolve_cnt,
    output logic             proto_err
);
    fpc_state_e       r_state;
    logic [31:0]      r_pc;
    logic             r_if_valid;
    logic [31:0]      r_if_instr;
    logic [31:0]      r_if_pc;
    logic [31:0]      r_if_pred_pc;
    logic             r_flush;
    logic [CNT_W-1:0] r_mispredict_cnt;
    logic [CNT_W-1:0] r_resolve_cnt;
    logic             r_proto_err;

    logic [31:0] w_pred_pc;
    logic [31:0] w_head;
    logic        w_q_full;
    logic        w_q_empty;
    logic        w_res_req;
    logic        w_res_ok;
    logic        w_perr;
    logic        w_mismatch;
    logic        w_fire;

    Predicter u_pred (
        .i_instr   (imem_rdata),
        .i_pc      (r_pc),
        .o_pred_pc (w_pred_pc)
    );

    pred_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_fire),
        .i_pop   (w_res_ok),
        .i_clear (w_mismatch),
        .i_data  (w_pred_pc),
        .o_head  (w_head),
        .o_full  (w_q_full),
        .o_empty (w_q_empty)
    );

    // Execute is flushed alongside us, so its resolves are dropped while in FLUSH.
    assign w_res_req  = resolve_valid & (r_state != FPC_FLUSH);
    assign w_res_ok   = w_res_req & ~w_q_empty;
    assign w_perr     = w_res_req & w_q_empty;
    assign w_mismatch = w_res_ok & (resolve_next_pc != w_head);
    assign w_fire     = (r_state == FPC_RUN) & imem_valid & ~w_q_full
                      & (~r_if_valid | if_ready) & ~w_mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= FPC_BOOT;
            r_pc             <= RESET_PC;
            r_if_valid       <= 1'b0;
            r_if_instr       <= '0;
            r_if_pc          <= '0;
            r_if_pred_pc     <= '0;
            r_flush          <= 1'b0;
            r_mispredict_cnt <= '0;
            r_resolve_cnt    <= '0;
            r_proto_err      <= 1'b0;
        end else begin
            r_flush <= 1'b0;
            if (w_mismatch) begin
                r_state <= FPC_FLUSH;
            end else begin
                case (r_state)
                    FPC_BOOT:  r_state <= FPC_RUN;
                    FPC_RUN:   r_state <= FPC_RUN;
                    FPC_FLUSH: r_state <= FPC_RUN;
                    default:   r_state <= FPC_BOOT;
                endcase
            end

            if (w_mismatch) begin
                r_pc       <= resolve_next_pc;
                r_if_valid <= 1'b0;
                r_flush    <= 1'b1;
            end else if (w_fire) begin
                r_if_valid   <= 1'b1;
                r_if_instr   <= imem_rdata;
                r_if_pc      <= r_pc;
                r_if_pred_pc <= w_pred_pc;
                r_pc         <= w_pred_pc;
            end else if (if_ready) begin
                r_if_valid <= 1'b0;
            end

            if (w_res_ok && r_resolve_cnt != '1)
                r_resolve_cnt <= r_resolve_cnt + CNT_W'(1);
            if (w_mismatch && r_mispredict_cnt != '1)
                r_mispredict_cnt <= r_mispredict_cnt + CNT_W'(1);
            if (w_perr)
                r_proto_err <= 1'b1;
        end
    end

    assign imem_addr      = r_pc;
    assign if_valid       = r_if_valid;
    assign if_instr       = r_if_instr;
    assign if_pc          = r_if_pc;
    assign if_pred_pc     = r_if_pred_pc;
    assign flush          = r_flush;
    assign q_full         = w_q_full;
    assign mispredict_cnt = r_mispredict_cnt;
    assign resolve_cnt    = r_resolve_cnt;
    assign proto_err      = r_proto_err;
endmodule
